// File: rtl/fir_pkg.sv
// Shared constants, state encoding and Q1.15 limits for the two-channel
// symmetric-FIR MAC scheduler.
package fir_pkg;

    localparam int unsigned NUM_TAPS   = 317;
    localparam int unsigned HALF       = NUM_TAPS / 2;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ACC_W      = 48;
    localparam int unsigned FRAC_SHIFT = 17;
    localparam int unsigned MAC_LAT    = 4;
    localparam int unsigned K_W        = $clog2(HALF + 1);
    localparam int unsigned D_W        = $clog2(MAC_LAT + 1);

    localparam logic signed [DATA_W-1:0] Q15_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Q15_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        MAC,
        DRAIN,
        ROUND
    } state_t;

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Control/data bus between the scheduler and the shared sample memory,
// coefficient ROM and MAC.
interface fir_mac_scheduler_if;
    import fir_pkg::*;

    logic                     mem_wr_en;
    logic                     mem_update_ptr;
    logic        [DATA_W-1:0] mem_x_in;
    logic                     mem_ch_sel;
    logic        [K_W-1:0]    k_index;
    logic                     rom_rd_en;
    logic                     mac_clear;
    logic                     mac_en;
    logic                     mac_center;
    logic signed [ACC_W-1:0]  acc_in;

    modport master (
        output mem_wr_en, mem_update_ptr, mem_x_in, mem_ch_sel, k_index,
               rom_rd_en, mac_clear, mac_en, mac_center,
        input  acc_in
    );

    modport slave (
        input  mem_wr_en, mem_update_ptr, mem_x_in, mem_ch_sel, k_index,
               rom_rd_en, mac_clear, mac_en, mac_center,
        output acc_in
    );

endinterface

// File: rtl/fir_round_sat.sv
// Combinational round-to-nearest, arithmetic shift and saturation of the
// MAC accumulator down to a DATA_W-bit signed fraction.
module fir_round_sat #(
    parameter int unsigned ACC_W      = 48,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAC_SHIFT = 17
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [ACC_W:0] RND  =
        {{(ACC_W-FRAC_SHIFT+1){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W+1-DATA_W){1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV =
        {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] q;

    always_comb begin
        r = {acc[ACC_W-1], acc} + RND;
        q = r >>> FRAC_SHIFT;
        if (q > MAXV) begin
            y = MAXV[DATA_W-1:0];
        end else if (q < MINV) begin
            y = MINV[DATA_W-1:0];
        end else begin
            y = q[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler sharing one symmetric-FIR MAC datapath between a
// left (ch0) and right (ch1) audio channel.
module fir_mac_scheduler
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ch0_valid,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic              ch1_valid,
    input  logic [DATA_W-1:0] ch1_data,
    fir_mac_scheduler_if.master dp,
    output logic [DATA_W-1:0] y_out,
    output logic              y_ch,
    output logic              y_valid,
    output logic              busy,
    output logic [1:0]        overrun,
    input  logic              overrun_clr
);

    localparam logic [K_W-1:0] K_LAST = K_W'(HALF);
    localparam logic [D_W-1:0] D_LAST = D_W'(MAC_LAT);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         pend;
    logic [DATA_W-1:0]  hold0;
    logic [DATA_W-1:0]  hold1;
    logic [DATA_W-1:0]  wr_data;
    logic               gch;
    logic               last_grant;
    logic [K_W-1:0]     k_cnt;
    logic [D_W-1:0]     d_cnt;
    logic               grant_fire;
    logic               grant_ch;
    logic [1:0]         grant_clr;
    logic [1:0]         vld;
    logic signed [DATA_W-1:0] rs_y;

    fir_round_sat #(
        .ACC_W      (ACC_W),
        .DATA_W     (DATA_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .acc (dp.acc_in),
        .y   (rs_y)
    );

    always_comb begin
        vld        = {ch1_valid, ch0_valid};
        grant_fire = (state == IDLE) && (pend != 2'b00);
        grant_ch   = (pend == 2'b11) ? ~last_grant : pend[1];
        grant_clr  = grant_fire ? (grant_ch ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        dp.mem_wr_en      = 1'b0;
        dp.mem_update_ptr = 1'b0;
        dp.mem_x_in       = '0;
        dp.mem_ch_sel     = gch;
        dp.k_index        = k_cnt;
        dp.rom_rd_en      = 1'b0;
        dp.mac_clear      = 1'b0;
        dp.mac_en         = 1'b0;
        dp.mac_center     = 1'b0;
        busy              = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (grant_fire) state_nxt = WRITE;
            end
            WRITE: begin
                dp.mem_wr_en      = 1'b1;
                dp.mem_update_ptr = 1'b1;
                dp.mem_x_in       = wr_data;
                state_nxt         = MAC;
            end
            MAC: begin
                dp.rom_rd_en  = 1'b1;
                dp.mac_en     = 1'b1;
                dp.mac_clear  = (k_cnt == '0);
                dp.mac_center = (k_cnt == K_LAST);
                if (k_cnt == K_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                // one extra count so ROUND reads acc_in after its final PREG edge
                if (d_cnt == D_LAST) state_nxt = ROUND;
            end
            ROUND: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend       <= '0;
            hold0      <= '0;
            hold1      <= '0;
            wr_data    <= '0;
            gch        <= 1'b0;
            last_grant <= 1'b1;
            overrun    <= '0;
            k_cnt      <= '0;
            d_cnt      <= '0;
            y_out      <= '0;
            y_ch       <= 1'b0;
            y_valid    <= 1'b0;
        end else begin
            pend <= (pend & ~grant_clr) | vld;
            if (ch0_valid) hold0 <= ch0_data;
            if (ch1_valid) hold1 <= ch1_data;
            // a sample granted this cycle is already copied to wr_data, so it is not lost
            overrun <= (overrun_clr ? 2'b00 : overrun) | (vld & pend & ~grant_clr);
            if (grant_fire) begin
                gch        <= grant_ch;
                last_grant <= grant_ch;
                wr_data    <= grant_ch ? hold1 : hold0;
            end
            if (state == MAC) begin
                k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + K_W'(1);
            end else begin
                k_cnt <= '0;
            end
            if (state == DRAIN) begin
                d_cnt <= (d_cnt == D_LAST) ? '0 : d_cnt + D_W'(1);
            end else begin
                d_cnt <= '0;
            end
            y_valid <= (state == ROUND);
            if (state == ROUND) begin
                y_out <= rs_y;
                y_ch  <= gch;
            end
        end
    end

endmodule
